hilo_regs: RTL

- HI/LO architectural register pair placed directly downstream of the integer multiply/divide unit.
- Captures the unit's 64-bit results and tracks whether a mul/div operation is in flight.
- Serves MFHI/MFLO/MTHI/MTLO from the execute stage, with stall interlocks and a watchdog on missing results.

---
 rtl/hilo_regs.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hilo_regs.sv
// HI/LO register pair behind the multiply/divide unit: captures 64-bit results,
// tracks the in-flight operation, and serves MFHI/MFLO/MTHI/MTLO with stall interlock.
module hilo_regs #(
    parameter int unsigned TMO_CYCLES = 40
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_md_start,
    input  logic        i_md_abort,
    input  logic        i_res_valid,
    input  logic [31:0] i_res_hi,
    input  logic [31:0] i_res_lo,
    input  logic        i_mfhi,
    input  logic        i_mflo,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_cmd_err,
    output logic        o_tmo_err
);

    localparam logic [7:0] TmoLimit = 8'(TMO_CYCLES);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        cmd_err_q, cmd_err_d;
    logic        tmo_q, tmo_d;
    logic [4:0]  cmds;
    logic        any_cmd, multi;

    assign cmds    = {i_md_start, i_mfhi, i_mflo, i_mthi, i_mtlo};
    assign any_cmd = |cmds;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi   = (cmds & (cmds - 5'd1)) != 5'd0;
    assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        cmd_err_d = multi;
        tmo_d     = tmo_q;
        o_stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!multi) begin
                    if (i_md_start) begin
                        state_d = StBusy;
                        cnt_d   = 8'd0;
                    end else if (i_mfhi) begin
                        rdata_d  = hi_q;
                        rvalid_d = 1'b1;
                    end else if (i_mflo) begin
                        rdata_d  = lo_q;
                        rvalid_d = 1'b1;
                    end else if (i_mthi) begin
                        hi_d = i_wdata;
                    end else if (i_mtlo) begin
                        lo_d = i_wdata;
                    end
                end
            end
            StBusy: begin
                o_stall = any_cmd & ~multi;
                cnt_d   = cnt_inc;
                // Abort beats a same-cycle result; a result beats the watchdog.
                if (i_md_abort) begin
                    state_d = StIdle;
                end else if (i_res_valid) begin
                    hi_d    = i_res_hi;
                    lo_d    = i_res_lo;
                    state_d = StIdle;
                end else if (cnt_inc == TmoLimit) begin
                    tmo_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            rdata_q   <= 32'd0;
            rvalid_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            cmd_err_q <= cmd_err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_rdata   = rdata_q;
    assign o_rvalid  = rvalid_q;
    assign o_busy    = (state_q == StBusy);
    assign o_cmd_err = cmd_err_q;
    assign o_tmo_err = tmo_q;

endmodule
